// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences one shared ALU, memory, PC, IR
// and register file per instruction phase, and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_op,
  output logic [ALU_W-1:0] alu_ctr,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_EXR = 4'd2,  S_WBR = 4'd3,
    S_EXI = 4'd4,  S_WBI = 4'd5,  S_MA  = 4'd6,  S_MRD = 4'd7,
    S_WBL = 4'd8,  S_MWR = 4'd9,  S_BR  = 4'd10, S_JMP = 4'd11
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam logic [ALU_W-1:0] ALU_ADDU = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(3'b101);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(3'b111);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(3'b010);

  state_t           state_q, state_nx;
  logic [5:0]       op_q, funct_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pc_wr_c, ir_wr_c, mem_rd_c, mem_wr_c, reg_wr_c;
  logic             reg_dst_c, mem_to_reg_c, alu_src_a_c, ext_op_c;
  logic             illegal_c, instr_done_c;
  logic [1:0]       pc_src_c, alu_src_b_c;
  logic [ALU_W-1:0] alu_ctr_c;

  function automatic logic is_rfunct(input logic [5:0] f);
    return (f == FN_ADDU) || (f == FN_ADD) || (f == FN_SUBU) ||
           (f == FN_SUB)  || (f == FN_SLT) || (f == FN_OR);
  endfunction

  function automatic logic [ALU_W-1:0] rfunct_alu(input logic [5:0] f);
    case (f)
      FN_ADD:          return ALU_ADD;
      FN_SUBU, FN_SUB: return ALU_SUB;
      FN_SLT:          return ALU_SLT;
      FN_OR:           return ALU_OR;
      default:         return ALU_ADDU;
    endcase
  endfunction

  // State register plus the IR-field and overflow captures used by later phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= '0;
      funct_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      if (state_q == S_ID) begin
        op_q    <= op;
        funct_q <= funct;
      end
      if (state_q == S_EXR) ovf_q <= overflow;
      if (instr_done_c && !illegal_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and per-phase control decode
  always_comb begin
    state_nx     = S_IF;
    pc_wr_c      = 1'b0;
    pc_src_c     = 2'b00;
    ir_wr_c      = 1'b0;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;
    reg_wr_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    ext_op_c     = 1'b0;
    alu_ctr_c    = ALU_ADDU;
    illegal_c    = 1'b0;
    instr_done_c = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd_c    = 1'b1;
        alu_src_b_c = 2'b01;
        ir_wr_c     = mem_ready;
        pc_wr_c     = mem_ready;
        state_nx    = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        // ALU forms the branch target speculatively while decoding
        alu_src_b_c = 2'b11;
        ext_op_c    = 1'b1;
        if (op == OP_R && is_rfunct(funct))         state_nx = S_EXR;
        else if (op == OP_ORI || op == OP_ADDIU)    state_nx = S_EXI;
        else if (op == OP_LW || op == OP_SW)        state_nx = S_MA;
        else if (op == OP_BEQ)                      state_nx = S_BR;
        else if (op == OP_J)                        state_nx = S_JMP;
        else begin
          illegal_c    = 1'b1;
          instr_done_c = 1'b1;
        end
      end
      S_EXR: begin
        alu_src_a_c = 1'b1;
        alu_ctr_c   = rfunct_alu(funct_q);
        state_nx    = S_WBR;
      end
      S_WBR: begin
        reg_dst_c    = 1'b1;
        alu_ctr_c    = rfunct_alu(funct_q);
        reg_wr_c     = !(ovf_q && (funct_q == FN_ADD || funct_q == FN_SUB));
        instr_done_c = 1'b1;
      end
      S_EXI: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        ext_op_c    = (op_q != OP_ORI);
        alu_ctr_c   = (op_q == OP_ORI) ? ALU_OR : ALU_ADDU;
        state_nx    = S_WBI;
      end
      S_WBI: begin
        reg_wr_c     = 1'b1;
        instr_done_c = 1'b1;
      end
      S_MA: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        ext_op_c    = 1'b1;
        state_nx    = (op_q == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        mem_rd_c = 1'b1;
        state_nx = mem_ready ? S_WBL : S_MRD;
      end
      S_WBL: begin
        reg_wr_c     = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
      end
      S_MWR: begin
        mem_wr_c     = 1'b1;
        instr_done_c = mem_ready;
        state_nx     = mem_ready ? S_IF : S_MWR;
      end
      S_BR: begin
        alu_src_a_c  = 1'b1;
        alu_ctr_c    = ALU_SUB;
        pc_src_c     = 2'b01;
        pc_wr_c      = zero;
        instr_done_c = 1'b1;
      end
      S_JMP: begin
        pc_wr_c      = 1'b1;
        pc_src_c     = 2'b10;
        instr_done_c = 1'b1;
      end
      default: state_nx = S_IF;
    endcase
  end

  // Reset asserted silences every control output immediately
  assign pc_wr      = rst_n & pc_wr_c;
  assign pc_src     = rst_n ? pc_src_c : 2'b00;
  assign ir_wr      = rst_n & ir_wr_c;
  assign mem_rd     = rst_n & mem_rd_c;
  assign mem_wr     = rst_n & mem_wr_c;
  assign reg_wr     = rst_n & reg_wr_c;
  assign reg_dst    = rst_n & reg_dst_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign alu_src_a  = rst_n & alu_src_a_c;
  assign alu_src_b  = rst_n ? alu_src_b_c : 2'b00;
  assign ext_op     = rst_n & ext_op_c;
  assign alu_ctr    = rst_n ? alu_ctr_c : '0;
  assign illegal    = rst_n & illegal_c;
  assign instr_done = rst_n & instr_done_c;
  assign instr_cnt  = cnt_q;
  assign state      = state_q;

endmodule
